// File: rtl/obc_dft_bit_serial_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : obc_dft_bit_serial_ctrl
// Brief    : Bit-serial sequencer for one 16-point OBC DFT output-bin ROM
//            slice. It latches a frame of 16 two's-complement samples and
//            presents one bit-plane per cycle to the external ROM slice, LSB
//            first, with the sign plane last and rom_m=1. It shift-accumulates
//            the returned ROM word into the bin result and hands the result
//            out over a valid/ready handshake.
// Options  : OBC_CTRL_ROM_PIPE_EN - register rom_data before the accumulator
//            and add a one-cycle FLUSH state that absorbs the last word.
// Revision : 1.0 - initial release
// ============================================================================
module obc_dft_bit_serial_ctrl #(
  parameter int DATA_W = 16,
  parameter int ROM_W  = 32,
  parameter int OUT_W  = 48
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [16*DATA_W-1:0] in_data,
  output logic [15:0]          rom_bits,
  output logic                 rom_m,
  input  logic [ROM_W-1:0]     rom_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_W-1:0]     out_data,
  output logic                 busy
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(DATA_W - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
`ifdef OBC_CTRL_ROM_PIPE_EN
  localparam logic [1:0] S_FLUSH = 2'd3;
`endif

  logic [1:0]        r_state;
  logic [IDX_W-1:0]  r_bit_idx;
  logic [DATA_W-1:0] r_smp [16];
  logic [OUT_W-1:0]  r_acc;
  logic [OUT_W-1:0]  r_out_data;
  logic              w_run;
  logic              w_last;
  logic [OUT_W-1:0]  w_acc_next;

  assign w_run     = (r_state == S_RUN);
  assign w_last    = (r_bit_idx == C_LAST_IDX);
  assign in_ready  = rst_n && (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign out_data  = r_out_data;
  assign rom_m     = w_run && w_last;

  // Current bit-plane of the latched samples; forced to zero outside RUN
  for (genvar k = 0; k < 16; k++) begin : g_plane
    assign rom_bits[k] = w_run & r_smp[k][r_bit_idx];
  end

`ifdef OBC_CTRL_ROM_PIPE_EN
  logic [ROM_W-1:0] r_rom_q;
  logic [IDX_W-1:0] r_pidx;
  logic             r_pvld;
  logic [OUT_W-1:0] w_rom_ext;

  assign busy       = w_run || (r_state == S_FLUSH);
  assign w_rom_ext  = {{(OUT_W-ROM_W){r_rom_q[ROM_W-1]}}, r_rom_q};
  assign w_acc_next = r_pvld ? (r_acc + (w_rom_ext << r_pidx)) : r_acc;

  // Register the ROM word together with the plane index it belongs to
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rom_q <= '0;
      r_pidx  <= '0;
      r_pvld  <= 1'b0;
    end else begin
      r_rom_q <= rom_data;
      r_pidx  <= r_bit_idx;
      r_pvld  <= w_run;
    end
  end
`else
  logic [OUT_W-1:0] w_rom_ext;

  assign busy       = w_run;
  assign w_rom_ext  = {{(OUT_W-ROM_W){rom_data[ROM_W-1]}}, rom_data};
  assign w_acc_next = r_acc + (w_rom_ext << r_bit_idx);
`endif

  // Frame sequencing, sample capture and shift-accumulate
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_bit_idx  <= '0;
      r_acc      <= '0;
      r_out_data <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            for (int k = 0; k < 16; k++) begin
              r_smp[k] <= in_data[k*DATA_W +: DATA_W];
            end
            r_bit_idx <= '0;
            r_acc     <= '0;
            r_state   <= S_RUN;
          end
        end
        S_RUN: begin
          r_acc <= w_acc_next;
          if (w_last) begin
            r_bit_idx <= '0;
`ifdef OBC_CTRL_ROM_PIPE_EN
            r_state   <= S_FLUSH;
`else
            r_out_data <= w_acc_next;
            r_state    <= S_DONE;
`endif
          end else begin
            r_bit_idx <= r_bit_idx + IDX_W'(1);
          end
        end
`ifdef OBC_CTRL_ROM_PIPE_EN
        S_FLUSH: begin
          // Last plane's registered word lands here
          r_acc      <= w_acc_next;
          r_out_data <= w_acc_next;
          r_state    <= S_DONE;
        end
`endif
        S_DONE: begin
          if (out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_obc_dft_bit_serial_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_obc_dft_bit_serial_ctrl
// Brief    : Self-checking bench for obc_dft_bit_serial_ctrl. A behavioural
//            ROM slice (stub constant or coefficient sum) feeds the DUT; the
//            expected bin value is the plain dot product of coefficients and
//            samples, or constant*(2^16-1) for a constant stub.
// Revision : 1.0 - initial release
// ============================================================================
module tb_obc_dft_bit_serial_ctrl;

  localparam int DATA_W = 16;
  localparam int ROM_W  = 32;
  localparam int OUT_W  = 48;
`ifdef OBC_CTRL_ROM_PIPE_EN
  localparam int LAT = DATA_W + 1;
`else
  localparam int LAT = DATA_W;
`endif
  localparam int PERIOD = LAT + 2;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 in_valid;
  logic                 in_ready;
  logic [16*DATA_W-1:0] in_data;
  logic [15:0]          rom_bits;
  logic                 rom_m;
  logic [ROM_W-1:0]     rom_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [OUT_W-1:0]     out_data;
  logic                 busy;

  int n_cmp = 0;
  int n_err = 0;

  logic                     rom_mode;   // 0: stub constant, 1: coefficient ROM
  logic [31:0]              stub_val;
  logic signed [15:0]       coef [16];
  logic [15:0]              smp  [16];
  int                       rom_sum;

  logic [15:0]              obs_planes [64];
  logic [63:0]              obs_m;
  int                       obs_lat;
  logic                     obs_busy_lat;
  logic [OUT_W-1:0]         obs_res;

  always #5 clk = ~clk;

  obc_dft_bit_serial_ctrl #(.DATA_W(DATA_W), .ROM_W(ROM_W), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .rom_bits(rom_bits), .rom_m(rom_m), .rom_data(rom_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  // Behavioural ROM slice: sum of selected coefficients, negated on the sign plane
  always_comb begin
    rom_sum = 0;
    for (int k = 0; k < 16; k++) begin
      if (rom_bits[k]) rom_sum = rom_sum + int'(coef[k]);
    end
    if (rom_mode) rom_data = rom_m ? 32'(-rom_sum) : 32'(rom_sum);
    else          rom_data = stub_val;
  end

  function automatic logic [OUT_W-1:0] dot_ref();
    longint s = 0;
    for (int k = 0; k < 16; k++) s += longint'(coef[k]) * longint'($signed(smp[k]));
    return s[OUT_W-1:0];
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic load_data();
    for (int k = 0; k < 16; k++) in_data[k*DATA_W +: DATA_W] = smp[k];
  endtask

  task automatic rand_frame(input bit new_coef);
    for (int k = 0; k < 16; k++) begin
      smp[k] = 16'($urandom);
      if (new_coef) coef[k] = 16'($urandom);
    end
  endtask

  // Drive one frame (DUT assumed idle) and record what it shows until out_valid
  task automatic run_frame();
    load_data();
    in_valid = 1'b1;
    obs_m = '0; obs_busy_lat = 1'b0; obs_lat = 0;
    for (int i = 0; i < 64; i++) obs_planes[i] = '0;
    step();
    in_valid = 1'b0;
    for (int c = 1; c < 64; c++) begin
      if (out_valid) begin obs_lat = c - 1; break; end
      obs_planes[c] = rom_bits;
      obs_m[c]      = rom_m;
      if (c == LAT) obs_busy_lat = busy;
      step();
    end
    obs_res = out_data;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(); step();
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %b exp 0", in_ready); end
    n_cmp++; if ({out_valid, busy, rom_m, rom_bits} !== 19'd0) begin n_err++;
      $display("FAIL reset_outputs: got ov=%b busy=%b m=%b bits=%h exp all 0", out_valid, busy, rom_m, rom_bits); end
    n_cmp++; if (out_data !== '0) begin n_err++; $display("FAIL reset_out_data: got %h exp 0", out_data); end
    rst_n = 1'b1;
    step();
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_release_in_ready: got %b exp 1", in_ready); end
  endtask

  task automatic test_zero();
    logic [15:0] orp;
    rom_mode = 1'b0; stub_val = '0;
    for (int k = 0; k < 16; k++) smp[k] = '0;
    run_frame();
    orp = '0;
    for (int c = 1; c < 64; c++) orp |= obs_planes[c];
    n_cmp++; if (obs_lat !== LAT) begin n_err++; $display("FAIL zero_latency: got %0d exp %0d", obs_lat, LAT); end
    n_cmp++; if (obs_res !== '0) begin n_err++; $display("FAIL zero_result: got %h exp 0", obs_res); end
    n_cmp++; if (obs_m !== (64'h1 << 16)) begin n_err++; $display("FAIL zero_rom_m_cycles: got %h exp %h", obs_m, 64'h1 << 16); end
    n_cmp++; if (orp !== '0) begin n_err++; $display("FAIL zero_rom_bits: got %h exp 0", orp); end
    n_cmp++; if (obs_busy_lat !== 1'b1) begin n_err++; $display("FAIL busy_last_cycle: got %b exp 1", obs_busy_lat); end
    consume();
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++;
      $display("FAIL zero_after_consume: got ov=%b ir=%b exp ov=0 ir=1", out_valid, in_ready); end
  endtask

  task automatic test_plane();
    logic [15:0] orp;
    rom_mode = 1'b0; stub_val = '0;
    for (int k = 0; k < 16; k++) smp[k] = '0;
    smp[0] = 16'h0001;
    run_frame();
    orp = '0;
    for (int c = 2; c < 64; c++) orp |= obs_planes[c];
    n_cmp++; if (obs_planes[1] !== 16'h0001) begin n_err++; $display("FAIL plane0_bits: got %h exp 0001", obs_planes[1]); end
    n_cmp++; if (orp !== 16'h0000) begin n_err++; $display("FAIL plane_rest_bits: got %h exp 0000", orp); end
    consume();
  endtask

  task automatic test_const();
    logic [31:0] vals [5];
    longint e;
    vals[0] = 32'd1; vals[1] = 32'hFFFF_FFFF;
    vals[2] = $urandom; vals[3] = $urandom; vals[4] = 32'h8000_0000;
    rom_mode = 1'b0;
    for (int i = 0; i < 5; i++) begin
      stub_val = vals[i];
      rand_frame(1'b0);
      run_frame();
      e = longint'($signed(stub_val)) * 64'sd65535;
      n_cmp++; if (obs_res !== e[OUT_W-1:0]) begin n_err++;
        $display("FAIL const_result[%0d]: got %h exp %h (rom=%h)", i, obs_res, e[OUT_W-1:0], stub_val); end
      n_cmp++; if (obs_lat !== LAT) begin n_err++; $display("FAIL const_latency[%0d]: got %0d exp %0d", i, obs_lat, LAT); end
      consume();
    end
  endtask

  task automatic test_hold();
    logic [OUT_W-1:0] exp1;
    rom_mode = 1'b1;
    rand_frame(1'b1);
    exp1 = dot_ref();
    run_frame();
    n_cmp++; if (obs_res !== exp1) begin n_err++; $display("FAIL hold_result: got %h exp %h", obs_res, exp1); end
    rand_frame(1'b0);
    load_data();
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      n_cmp++; if (out_valid !== 1'b1 || out_data !== exp1 || in_ready !== 1'b0 || busy !== 1'b0) begin n_err++;
        $display("FAIL hold_stall[%0d]: got ov=%b od=%h ir=%b busy=%b exp ov=1 od=%h ir=0 busy=0",
                 i, out_valid, out_data, in_ready, busy, exp1); end
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin n_err++;
      $display("FAIL hold_handshake_no_capture: got ov=%b ir=%b busy=%b exp 0 1 0", out_valid, in_ready, busy); end
    in_valid = 1'b0;
    exp1 = dot_ref();
    run_frame();
    n_cmp++; if (obs_res !== exp1) begin n_err++; $display("FAIL hold_next_frame: got %h exp %h", obs_res, exp1); end
    consume();
  endtask

  task automatic test_reset_mid();
    logic [OUT_W-1:0] e;
    rom_mode = 1'b1;
    rand_frame(1'b1);
    load_data();
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (7) step();
    rst_n = 1'b0;
    step();
    n_cmp++; if (out_valid !== 1'b0 || rom_bits !== 16'h0 || rom_m !== 1'b0 || busy !== 1'b0) begin n_err++;
      $display("FAIL midreset_outputs: got ov=%b bits=%h m=%b busy=%b exp all 0", out_valid, rom_bits, rom_m, busy); end
    rst_n = 1'b1;
    step();
    n_cmp++; if (in_ready !== 1'b1 || out_data !== '0) begin n_err++;
      $display("FAIL midreset_idle: got ir=%b od=%h exp ir=1 od=0", in_ready, out_data); end
    rand_frame(1'b1);
    e = dot_ref();
    run_frame();
    n_cmp++; if (obs_res !== e || obs_lat !== LAT) begin n_err++;
      $display("FAIL midreset_next_frame: got %h lat %0d exp %h lat %0d", obs_res, obs_lat, e, LAT); end
    consume();
  endtask

  task automatic test_random();
    logic [OUT_W-1:0] e;
    rom_mode = 1'b1;
    for (int i = 0; i < 15; i++) begin
      rand_frame(1'b1);
      if (i == 0) for (int k = 0; k < 16; k++) begin smp[k] = 16'h8000; coef[k] = 16'sh7FFF; end
      if (i == 1) for (int k = 0; k < 16; k++) begin smp[k] = 16'h8000; coef[k] = 16'sh8000; end
      e = dot_ref();
      run_frame();
      n_cmp++; if (obs_res !== e) begin n_err++; $display("FAIL random_result[%0d]: got %h exp %h", i, obs_res, e); end
      consume();
    end
  endtask

  task automatic test_back_to_back();
    logic [OUT_W-1:0] exp_q[$];
    logic [OUT_W-1:0] e;
    int last_acc = -1;
    int got = 0;
    bit accepted;
    rom_mode = 1'b1;
    rand_frame(1'b1);
    load_data();
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 400 && got < 5; cyc++) begin
      accepted = 1'b0;
      if (out_valid) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        n_cmp++; if (out_data !== e) begin n_err++; $display("FAIL b2b_result[%0d]: got %h exp %h", got, out_data, e); end
        got++;
      end
      if (in_ready) begin
        if (last_acc >= 0) begin
          n_cmp++; if (cyc - last_acc !== PERIOD) begin n_err++;
            $display("FAIL b2b_period: got %0d exp %0d", cyc - last_acc, PERIOD); end
        end
        last_acc = cyc;
        exp_q.push_back(dot_ref());
        accepted = 1'b1;
      end
      step();
      if (accepted) begin rand_frame(1'b0); load_data(); end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    n_cmp++; if (got !== 5) begin n_err++; $display("FAIL b2b_count: got %0d exp 5", got); end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    rom_mode = 1'b0; stub_val = '0;
    for (int k = 0; k < 16; k++) begin coef[k] = '0; smp[k] = '0; end
    test_reset();
    test_zero();
    test_plane();
    test_const();
    test_hold();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
